// File: rtl/data_mem_pkg.sv
// Shared address map and UART state encoding for the data-side memory block.
package data_mem_pkg;

  localparam logic [31:0] MMIO_BASE        = 32'h8000_0000;
  localparam logic [31:0] UART_TXDATA_ADDR = MMIO_BASE + 32'h0;
  localparam logic [31:0] UART_STATUS_ADDR = MMIO_BASE + 32'h4;
  localparam logic [31:0] CYCLE_ADDR       = MMIO_BASE + 32'h8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  // All accesses are word accesses, so the byte offset never takes part in decode.
  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/data_mem_mmio_uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, CLK_DIV cycles per bit.
module uart_tx
  import data_mem_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  uart_state_e      state, state_n;
  logic [DIV_W-1:0] div, div_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             bit_done;

  assign bit_done = (div == DIV_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      div   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      div   <= div_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    div_n   = bit_done ? '0 : div + 1'b1;
    idx_n   = idx;
    shreg_n = shreg;
    busy    = 1'b1;
    tx      = 1'b1;
    unique case (state)
      IDLE: begin
        busy  = 1'b0;
        div_n = '0;
        idx_n = '0;
        if (start) begin
          state_n = START;
          shreg_n = data;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_done) state_n = DATA;
      end
      DATA: begin
        tx = shreg[0];
        if (bit_done) begin
          shreg_n = {1'b0, shreg[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (bit_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Data memory port of the single-cycle core: word RAM, cycle counter and UART
// transmitter mapped into one address space, with combinational read data.
module data_mem_mmio
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int CLK_DIV     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        uart_tx
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      cycle_cnt;
  logic [IDX_W-1:0] ram_idx;
  logic             ram_sel, txdata_sel, status_sel, cycle_sel;
  logic             uart_busy;
  logic             unused_addr_bits;

  assign ram_idx          = addr[IDX_W+1:2];
  assign ram_sel          = (addr[31:IDX_W+2] == '0);
  assign txdata_sel       = word_match(addr, UART_TXDATA_ADDR);
  assign status_sel       = word_match(addr, UART_STATUS_ADDR);
  assign cycle_sel        = word_match(addr, CYCLE_ADDR);
  assign unused_addr_bits = ^addr[1:0];

  // NOTE: the RAM array has no reset; clearing it would force it out of
  // block RAM into flops, and software never relies on its power-up contents.
  always_ff @(posedge clock) begin
    if (we && ram_sel) mem[ram_idx] <= wdata;
  end

  // A clearing write takes priority so the following cycle reads zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 cycle_cnt <= '0;
    else if (we && cycle_sel)   cycle_cnt <= '0;
    else                        cycle_cnt <= cycle_cnt + 32'd1;
  end

  uart_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_uart (
    .clock(clock),
    .reset(reset),
    .start(we && txdata_sel),
    .data (wdata[7:0]),
    .busy (uart_busy),
    .tx   (uart_tx)
  );

  always_comb begin
    rdata = '0;
    if (ram_sel)         rdata = mem[ram_idx];
    else if (status_sel) rdata = {31'b0, uart_busy};
    else if (cycle_sel)  rdata = cycle_cnt;
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Randomised scoreboard bench for data_mem_mmio against a timeline model of
// RAM contents, counter epochs and UART frames.
module tb_data_mem_mmio;

  localparam int DEPTH = 64;
  localparam int CD    = 4;
  localparam int FRAME = 10 * CD;
  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;
  localparam logic [31:0] A_CYC = 32'h8000_0008;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        we    = 1'b0;
  logic [31:0] rdata;
  logic        uart_tx;

  data_mem_mmio #(.DEPTH_WORDS(DEPTH), .CLK_DIV(CD)) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata),
    .we(we), .rdata(rdata), .uart_tx(uart_tx)
  );

  always #5 clock = ~clock;

  int unsigned edges = 0;
  always @(posedge clock) edges++;

  typedef struct {
    string       name;
    bit          is_tx;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_obs = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < n_obs; i++) begin
      if (q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check(e.name, e.is_tx ? {31'b0, uart_tx} : rdata, e.val);
      end
    end
  end

  // Reference model: RAM image, counter epoch, and at most one frame in flight.
  logic [31:0] mem_m [DEPTH];
  int unsigned cyc_base    = 0;
  bit          frame_on    = 0;
  int unsigned frame_start = 0;
  logic [9:0]  frame_bits  = '0;

  function automatic logic exp_busy(input int unsigned v);
    return frame_on && ((v - frame_start) < FRAME);
  endfunction

  function automatic logic exp_tx(input int unsigned v);
    if (!exp_busy(v)) return 1'b1;
    return frame_bits[(v - frame_start) / CD];
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (a < DEPTH * 4)                return mem_m[a >> 2];
    if ((a & ~32'd3) == A_ST)         return {31'b0, exp_busy(edges)};
    if ((a & ~32'd3) == A_CYC)        return edges - cyc_base;
    return 32'd0;
  endfunction

  task automatic apply_write(input logic [31:0] a, input logic [31:0] d);
    if (a < DEPTH * 4) begin
      mem_m[a >> 2] = d;
    end else if ((a & ~32'd3) == A_TX) begin
      if (!exp_busy(edges)) begin
        frame_on    = 1;
        frame_start = edges + 1;
        frame_bits  = {1'b1, d[7:0], 1'b0};
      end
    end else if ((a & ~32'd3) == A_CYC) begin
      cyc_base = edges + 1;
    end
  endtask

  task automatic push(input string nm, input bit is_tx, input logic [31:0] v);
    exp_t e;
    e.name = nm; e.is_tx = is_tx; e.val = v;
    q.push_back(e);
  endtask

  // One bus cycle: drive after the edge, queue expectations, update the model.
  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input bit rd, input bit txc, input string nm);
    int n;
    @(posedge clock); #1;
    we = w; addr = a; wdata = d;
    n = 0;
    if (rd)  begin push(nm, 0, exp_read(a)); n++; end
    if (txc) begin push({nm, "_tx"}, 1, {31'b0, exp_tx(edges)}); n++; end
    n_obs = n;
    if (w) apply_write(a, d);
  endtask

  task automatic release_reset();
    @(posedge clock); #1;
    reset = 1'b1; we = 1'b0; addr = A_CYC;
    cyc_base = edges;
    frame_on = 0;
    push("rel_cycle", 0, 32'd0);
    push("rel_tx", 1, 32'd1);
    n_obs = 2;
  endtask

  function automatic logic [31:0] rand_unmapped();
    logic [31:0] a;
    a = $urandom | 32'h0001_0000;
    if (a[31:4] == 28'h800_0000) a = 32'h8000_000C;
    return a;
  endfunction

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while held.
    repeat (2) @(posedge clock);
    #1; addr = A_CYC;
    push("rst_cycle", 0, 32'd0);
    push("rst_tx", 1, 32'd1);
    n_obs = 2;
    @(posedge clock); #1; addr = A_ST;
    push("rst_status", 0, 32'd0);
    n_obs = 1;
    release_reset();

    // Counter after 100 edges, then a clearing write.
    for (int i = 0; i < 99; i++) step(0, 32'h0, 32'h0, 0, 0, "idle");
    step(0, A_CYC, 32'h0, 0, 0, "cyc100");
    push("cyc100", 0, 32'd100); n_obs = 1;
    step(1, A_CYC, 32'h1234, 0, 0, "cyc_clr");
    step(0, A_CYC, 32'h0, 0, 0, "cyc_after_clr");
    push("cyc_after_clr", 0, 32'd0); n_obs = 1;
    step(0, A_CYC, 32'h0, 1, 0, "cyc_run");

    // Fill the RAM so every random read has a known value.
    for (int i = 0; i < DEPTH; i++) step(1, i * 4, $urandom, 0, 0, "fill");

    // Directed RAM cases, including byte offset and full-word store.
    step(1, 32'h10, 32'hDEAD_BEEF, 0, 0, "w10");
    step(0, 32'h10, 32'h0, 0, 0, "r10");
    push("r10", 0, 32'hDEAD_BEEF); n_obs = 1;
    step(0, 32'h13, 32'h0, 0, 0, "r13");
    push("r13", 0, 32'hDEAD_BEEF); n_obs = 1;
    step(1, 32'h14, 32'h11, 0, 0, "w14");
    step(0, 32'h14, 32'h0, 0, 0, "r14");
    push("r14", 0, 32'h11); n_obs = 1;

    // Unmapped addresses read zero and writes leave RAM, counter and UART alone.
    step(0, 32'h4000_0000, 32'h0, 1, 0, "r_4000");
    step(0, 32'h8000_000C, 32'h0, 1, 0, "r_800c");
    step(1, 32'h4000_0000, 32'hFFFF_FFFF, 0, 0, "w_4000");
    step(1, 32'h8000_000C, 32'hFFFF_FFFF, 0, 0, "w_800c");
    step(1, A_ST, 32'hFFFF_FFFF, 0, 0, "w_status");
    step(0, 32'h0, 32'h0, 1, 0, "ram0_kept");
    step(0, 32'h10, 32'h0, 1, 0, "ram10_kept");
    step(0, A_ST, 32'h0, 1, 1, "uart_kept");
    step(0, A_CYC, 32'h0, 1, 0, "cyc_kept");

    // 0xA5 frame with a dropped write mid-frame; every cycle checked.
    step(1, A_TX, 32'hA5, 0, 0, "tx_a5");
    for (int k = 0; k < FRAME + 6; k++) begin
      if (k == 10) step(1, A_TX, 32'h55, 1, 1, "tx_busy_wr");
      else         step(0, A_ST, 32'h0, 1, 1, "frame_a5");
    end

    // Back-to-back: a write in the first idle cycle is accepted.
    step(1, A_TX, 32'h3C, 0, 0, "tx_3c");
    for (int k = 0; k < 2 * FRAME + 6; k++) begin
      if (k == FRAME) step(1, A_TX, 32'hC3, 0, 1, "tx_b2b");
      else            step(0, A_ST, 32'h0, 1, 1, "frame_b2b");
    end

    // Reset asserted at cycle 15 of a frame.
    step(1, A_TX, 32'hF0, 0, 0, "tx_f0");
    for (int k = 0; k < 15; k++) step(0, A_ST, 32'h0, 1, 1, "pre_rst");
    @(posedge clock); #1;
    we = 1'b0; addr = A_ST;
    #2 reset = 1'b0;
    frame_on = 0;
    push("midrst_tx", 1, 32'd1);
    n_obs = 1;
    #1 check("midrst_tx_immediate", {31'b0, uart_tx}, 32'd1);
    repeat (3) begin @(posedge clock); #1; n_obs = 0; end
    release_reset();
    step(0, A_ST, 32'h0, 1, 1, "post_rst_status");
    for (int k = 0; k < FRAME; k++) step(0, A_ST, 32'h0, 0, 1, "no_resume");

    // Randomised mix of all access types.
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 7);
      case (op)
        0: step(1, ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(0, 3), $urandom, 0, 1, "rnd_wram");
        1, 2: step(0, ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(0, 3), 32'h0, 1, 1, "rnd_rram");
        3: step(0, rand_unmapped(), 32'h0, 1, 1, "rnd_runmap");
        4: step(1, rand_unmapped(), $urandom, 0, 1, "rnd_wunmap");
        5: step(0, A_CYC + $urandom_range(0, 3), 32'h0, 1, 1, "rnd_cycle");
        6: step($urandom_range(0, 15) == 0, A_CYC, 32'h0, 0, 1, "rnd_wcyc");
        default: begin
          if ($urandom_range(0, 3) == 0) step(1, A_TX, $urandom, 0, 1, "rnd_tx");
          else                           step(0, A_ST, 32'h0, 1, 1, "rnd_status");
        end
      endcase
    end

    @(posedge clock); #1;
    we = 1'b0; n_obs = 0;
    @(negedge clock); #1;
    check("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
